// File: rtl/inertial_integrator.sv
// inertial_integrator: gyro offset calibration, rate integration and
// accelerometer fusion producing 16-bit pitch/roll/yaw angles.
module inertial_integrator #(
    parameter int CAL_LOG2    = 9,
    parameter int FUSION_STEP = 1024,
    parameter int ACC_SCALE   = 327
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strt_cal,
    input  logic               vld,
    input  logic signed [15:0] ptch_rt,
    input  logic signed [15:0] roll_rt,
    input  logic signed [15:0] yaw_rt,
    input  logic signed [15:0] ax,
    input  logic signed [15:0] ay,
    output logic               cal_done,
    output logic               vld_out,
    output logic signed [15:0] ptch,
    output logic signed [15:0] roll,
    output logic signed [15:0] yaw
);

    localparam int AW = 16 + CAL_LOG2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAL  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic signed [26:0] FUS_POS = 27'(FUSION_STEP);
    localparam logic signed [26:0] FUS_NEG = -27'(FUSION_STEP);
    localparam logic        [31:0] ACC_K   = 32'(ACC_SCALE);

    // Sign-extend a raw rate to calibration accumulator width.
    function automatic logic [AW-1:0] sext_acc(input logic [15:0] v);
        return {{CAL_LOG2{v[15]}}, v};
    endfunction

    // Bias-corrected rate: 17-bit difference sign-extended to integrator width.
    function automatic logic signed [26:0] rate_comp(input logic [15:0] rt,
                                                     input logic [15:0] off);
        logic [16:0] d;
        d = {rt[15], rt} - {off[15], off};
        return {{10{d[16]}}, d};
    endfunction

    // Fixed-step nudge of the angle toward the accelerometer angle.
    function automatic logic signed [26:0] fusion_term(input logic signed [15:0] acc_ang,
                                                       input logic signed [15:0] ang);
        logic signed [26:0] t;
        if (acc_ang > ang) begin
            t = FUS_POS;
        end else if (acc_ang < ang) begin
            t = FUS_NEG;
        end else begin
            t = 27'sd0;
        end
        return t;
    endfunction

    logic [1:0]          r_state;
    logic [CAL_LOG2-1:0] r_cnt;
    logic [AW-1:0]       r_acc_p, r_acc_r, r_acc_y;
    logic [15:0]         r_off_p, r_off_r, r_off_y;
    logic signed [26:0]  r_int_p, r_int_r, r_int_y;
    logic                r_cal_done;
    logic                r_vld_out;

    logic [AW-1:0]       w_sum_p, w_sum_r, w_sum_y;
    logic [31:0]         w_prod_p, w_prod_r;
    logic signed [15:0]  w_acc_ang_p, w_acc_ang_r;
    logic signed [26:0]  w_next_p, w_next_r, w_next_y;
    logic                w_unused_bits;

    // Running calibration sums including the sample arriving this clock.
    assign w_sum_p = r_acc_p + sext_acc(ptch_rt);
    assign w_sum_r = r_acc_r + sext_acc(roll_rt);
    assign w_sum_y = r_acc_y + sext_acc(yaw_rt);

    // Accelerometer angles: product >>> 13, low 16 bits.
    assign w_prod_p    = {{16{ay[15]}}, ay} * ACC_K;
    assign w_prod_r    = {{16{ax[15]}}, ax} * ACC_K;
    assign w_acc_ang_p = w_prod_p[28:13];
    assign w_acc_ang_r = w_prod_r[28:13];

    // Next integrator values; fusion compares against the pre-update angle.
    assign w_next_p = r_int_p + rate_comp(ptch_rt, r_off_p) + fusion_term(w_acc_ang_p, r_int_p[26:11]);
    assign w_next_r = r_int_r + rate_comp(roll_rt, r_off_r) + fusion_term(w_acc_ang_r, r_int_r[26:11]);
    assign w_next_y = r_int_y + rate_comp(yaw_rt, r_off_y);

    assign w_unused_bits = ^{w_prod_p[31:29], w_prod_p[12:0], w_prod_r[31:29], w_prod_r[12:0],
                             w_sum_p[CAL_LOG2-1:0], w_sum_r[CAL_LOG2-1:0], w_sum_y[CAL_LOG2-1:0]};

    assign ptch     = r_int_p[26:11];
    assign roll     = r_int_r[26:11];
    assign yaw      = r_int_y[26:11];
    assign cal_done = r_cal_done;
    assign vld_out  = r_vld_out;

    // Mode control, calibration accumulation and angle integration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc_p    <= '0;
            r_acc_r    <= '0;
            r_acc_y    <= '0;
            r_off_p    <= 16'h0000;
            r_off_r    <= 16'h0000;
            r_off_y    <= 16'h0000;
            r_int_p    <= 27'sd0;
            r_int_r    <= 27'sd0;
            r_int_y    <= 27'sd0;
            r_cal_done <= 1'b0;
            r_vld_out  <= 1'b0;
        end else begin
            r_cal_done <= 1'b0;
            r_vld_out  <= 1'b0;
            if (strt_cal) begin
                // Restart wins over any coincident sample.
                r_state <= ST_CAL;
                r_cnt   <= '0;
                r_acc_p <= '0;
                r_acc_r <= '0;
                r_acc_y <= '0;
            end else begin
                case (r_state)
                    ST_CAL: begin
                        if (vld) begin
                            r_acc_p <= w_sum_p;
                            r_acc_r <= w_sum_r;
                            r_acc_y <= w_sum_y;
                            r_cnt   <= r_cnt + CAL_LOG2'(1);
                            if (r_cnt == '1) begin
                                r_off_p    <= w_sum_p[AW-1:CAL_LOG2];
                                r_off_r    <= w_sum_r[AW-1:CAL_LOG2];
                                r_off_y    <= w_sum_y[AW-1:CAL_LOG2];
                                r_int_p    <= 27'sd0;
                                r_int_r    <= 27'sd0;
                                r_int_y    <= 27'sd0;
                                r_cal_done <= 1'b1;
                                r_state    <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (vld) begin
                            r_int_p   <= w_next_p;
                            r_int_r   <= w_next_r;
                            r_int_y   <= w_next_y;
                            r_vld_out <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inertial_integrator.sv
// Self-checking bench for inertial_integrator: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_inertial_integrator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cal = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] ptch_rt = 16'h0000, roll_rt = 16'h0000, yaw_rt = 16'h0000;
    logic [15:0] ax = 16'h0000, ay = 16'h0000;
    logic        cal_done, vld_out;
    logic [15:0] ptch, roll, yaw;

    inertial_integrator dut (
        .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld),
        .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
        .ax(ax), .ay(ay),
        .cal_done(cal_done), .vld_out(vld_out),
        .ptch(ptch), .roll(roll), .yaw(yaw)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cd_seen = 0;

    // Reference model: 0 idle, 1 calibrating, 2 running
    int m_mode = 0;
    int m_cnt  = 0;
    int m_sum [3];
    int m_off [3];
    int m_int [3];
    int exp_cd = 0;
    int exp_vo = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int wrap(input longint x, input int bits);
        longint m;
        m = longint'(1) << bits;
        x = x % m;
        if (x < 0) x = x + m;
        if (x >= m / 2) x = x - m;
        return int'(x);
    endfunction

    function automatic int angle(input int integ);
        return integ >>> 11;
    endfunction

    function automatic int acc_angle(input int a);
        return wrap(longint'((a * 327) >>> 13), 16);
    endfunction

    function automatic int fus(input int acc_a, input int ang);
        if (acc_a > ang) return 1024;
        if (acc_a < ang) return -1024;
        return 0;
    endfunction

    task automatic model_clear();
        m_mode = 0; m_cnt = 0; exp_cd = 0; exp_vo = 0;
        for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0; m_off[i] = 0; m_int[i] = 0;
        end
    endtask

    task automatic model_step();
        int rt [3];
        int ap, ar;
        rt[0] = s16(ptch_rt); rt[1] = s16(roll_rt); rt[2] = s16(yaw_rt);
        exp_cd = 0; exp_vo = 0;
        if (!rst_n) begin
            model_clear();
        end else if (strt_cal) begin
            m_mode = 1; m_cnt = 0;
            for (int i = 0; i < 3; i++) m_sum[i] = 0;
        end else if (vld && m_mode == 1) begin
            for (int i = 0; i < 3; i++) m_sum[i] += rt[i];
            m_cnt++;
            if (m_cnt == 512) begin
                for (int i = 0; i < 3; i++) begin
                    m_off[i] = wrap(longint'(m_sum[i] >>> 9), 16);
                    m_int[i] = 0;
                end
                exp_cd = 1;
                m_mode = 2;
            end
        end else if (vld && m_mode == 2) begin
            ap = fus(acc_angle(s16(ay)), angle(m_int[0]));
            ar = fus(acc_angle(s16(ax)), angle(m_int[1]));
            m_int[0] = wrap(longint'(m_int[0]) + rt[0] - m_off[0] + ap, 27);
            m_int[1] = wrap(longint'(m_int[1]) + rt[1] - m_off[1] + ar, 27);
            m_int[2] = wrap(longint'(m_int[2]) + rt[2] - m_off[2], 27);
            exp_vo = 1;
        end
    endtask

    // One clock of stimulus; the model advances on the same edge the DUT samples.
    task automatic cyc(input bit s, input bit v, input logic [15:0] p, input logic [15:0] r,
                       input logic [15:0] y, input logic [15:0] x, input logic [15:0] yy);
        strt_cal = s; vld = v; ptch_rt = p; roll_rt = r; yaw_rt = y; ax = x; ay = yy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'h1234, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
        strt_cal = 1'b0; vld = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cal_done === 1'b1) cd_seen++;
            chk("ptch", s16(ptch), angle(m_int[0]));
            chk("roll", s16(roll), angle(m_int[1]));
            chk("yaw", s16(yaw), angle(m_int[2]));
            chk("cal_done", int'(cal_done), exp_cd);
            chk("vld_out", int'(vld_out), exp_vo);
        end
    end

    initial begin
        int cd0;
        model_clear();

        // Reset held with inputs active, then vld ignored in IDLE
        do_reset();
        chk("rst_ptch", s16(ptch), 0);
        chk("rst_cal_done", int'(cal_done), 0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'h0400, 16'h0500, 16'h0600, 16'h0000, 16'h0000);
        idle(1);
        chk("idle_vld_out", int'(vld_out), 0);
        chk("idle_ptch", s16(ptch), 0);

        // Calibration on constant 0x0010
        cd0 = cd_seen;
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 511; i++) cyc(1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
        chk("cal_no_early", cd_seen - cd0, 0);
        cyc(1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
        chk("cal_done_512", int'(cal_done), 1);
        chk("model_off", m_off[0], 16);
        idle(1);
        chk("cal_pulses", cd_seen - cd0, 1);
        chk("cal_angle", s16(ptch), 0);

        // Rate integration
        cyc(1'b0, 1'b1, 16'h0810, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
        chk("rate1_ptch", s16(ptch), 1);
        chk("rate1_int", m_int[0], 2048);
        chk("rate1_vo", int'(vld_out), 1);
        cyc(1'b0, 1'b1, 16'h0810, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
        chk("rate2_ptch", s16(ptch), 1);
        chk("rate2_int", m_int[0], 3072);
        idle(1);
        chk("rate_vo_off", int'(vld_out), 0);

        // Fusion convergence with zero-bias calibration
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 512; i++) cyc(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int k = 1; k <= 98; k++) begin
            cyc(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd1000);
            chk("fus_ptch", s16(ptch), (k / 2 < 39) ? k / 2 : 39);
            if (k == 78) chk("fus_int78", m_int[0], 79872);
        end
        chk("fus_int_end", m_int[0], 79872);
        chk("fus_yaw", s16(yaw), 0);

        // Restart coincident with vld during RUN
        cd0 = cd_seen;
        cyc(1'b1, 1'b1, 16'h0800, 16'h0800, 16'h0800, 16'h0000, 16'h0000);
        idle(1);
        chk("restart_vo", int'(vld_out), 0);
        chk("restart_ptch", s16(ptch), 39);
        for (int i = 0; i < 511; i++) cyc(1'b0, 1'b1, 16'hFFF0, 16'h0020, 16'h0003, 16'h0000, 16'h0000);
        chk("restart_no_early", cd_seen - cd0, 0);
        cyc(1'b0, 1'b1, 16'hFFF0, 16'h0020, 16'h0003, 16'h0000, 16'h0000);
        chk("restart_done", int'(cal_done), 1);
        chk("restart_off", m_off[0], -16);

        // Randomized traffic including occasional restarts and wrap
        for (int i = 0; i < 2500; i++) begin
            cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) < 6),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 1200; i++) begin
            cyc(1'b0, ($urandom_range(0, 9) < 6),
                16'($urandom_range(0, 4095)), 16'($urandom), 16'($urandom_range(0, 255)),
                16'($urandom), 16'($urandom));
        end

        // Reset mid-calibration
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
        do_reset();
        cd0 = cd_seen;
        for (int i = 0; i < 600; i++) cyc(1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
        chk("rstcal_no_done", cd_seen - cd0, 0);
        chk("rstcal_vo", int'(vld_out), 0);
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 512; i++) cyc(1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
        chk("rstcal_done", int'(cal_done), 1);
        idle(2);
        chk("rstcal_pulses", cd_seen - cd0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
